// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry elastic register (main + skid) between pipeline
// stages or between the core and a memory/peripheral port.
//
// Handshake: a word moves on a side only in a cycle where both valid and
// ready are high at the rising clock edge (accept = in_valid & in_ready,
// pop = out_valid & out_ready). A valid word stays on out_data unchanged
// until it is popped; in_ready, out_valid and out_data come straight from
// registers, so there is no combinational path from out_ready to in_ready.
//
// Optional build macro: PIPE_STALL_COUNT_EN adds the saturating stall_count
// output (cycles with out_valid = 1 and out_ready = 0).
//
// dbg_state exposes the occupancy FSM (0 = EMPTY, 1 = BUSY, 2 = FULL).
module pipe_skid_buffer #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter int unsigned      CNT_WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       dbg_state
`ifdef PIPE_STALL_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Per-cycle decisions made by the next-state logic
  logic accept;
  logic pop;
  logic load_main_in;    // main <= in_data
  logic load_main_skid;  // main <= skid (FULL drains into BUSY)
  logic load_skid_in;    // skid <= in_data

  // Outputs are decoded from registered state only
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_data  = main_q;
  assign dbg_state = state;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // State register: asynchronous clear to EMPTY
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and data-load decode; flush overrides everything and leaves
  // the data registers untouched (a concurrent accept is simply dropped)
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            next_state   = BUSY;
          end
        end
        BUSY: begin
          case ({accept, pop})
            2'b10: begin
              load_skid_in = 1'b1;
              next_state   = FULL;
            end
            2'b11: begin
              load_main_in = 1'b1;
              next_state   = BUSY;
            end
            2'b01: begin
              next_state = EMPTY;
            end
            default: begin
              next_state = BUSY;
            end
          endcase
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen
          if (pop) begin
            load_main_skid = 1'b1;
            next_state     = BUSY;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  // Data registers: main holds the oldest word, skid the one behind it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_q <= INIT;
      skid_q <= INIT;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_STALL_COUNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  assign stall_count = stall_q;

  // Saturating count of cycles where a word waits on downstream; reset only
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end
`else
  // Counter width only matters when the stall counter is built in
  if (CNT_WIDTH > 0) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Two-entry elastic pipeline register with a valid/ready handshake on both sides. It is the consuming-end counterpart of the plain enable register.
- Sits between MIPS32 pipeline stages, or between the core and a memory or peripheral port.
- Absorbs one cycle of downstream back-pressure without a combinational ready path from out_ready to in_ready.
- Preserves order. Never drops or duplicates a word except on flush.

Parameters:
- WIDTH, 32, data word width in bits.
- INIT, 0, reset value of both data registers (main and skid).
- CNT_WIDTH, 16, width of stall counter; used only when the optional feature is compiled in.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- flush  input  1  synchronous discard of all held words.
- in_valid  input  1  upstream word present.
- in_ready  output  1  buffer can accept this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  word present at output.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  oldest held word.
- stall_count  output  CNT_WIDTH  present only with PIPE_STALL_COUNT_EN.

Behaviour:
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready. Both are sampled at the rising edge.
- State register: EMPTY, BUSY (main full), FULL (main + skid full). Data registers: main, skid.
- Decoded outputs:
  - out_valid = (state != EMPTY).
  - out_data = main.
  - in_ready = (state != FULL).
  - All three are decoded from registers only. No combinational path from in_* or out_ready to any output.
- Reset (reset = 0, asynchronous): state = EMPTY, main = skid = INIT. Therefore in_ready = 1, out_valid = 0, out_data = INIT, stall_count = 0. Release is sampled on the clock; first accept is possible on the first edge after reset goes high.
- Transitions when flush = 0:
  - EMPTY: accept -> main <= in_data, BUSY. Otherwise hold.
  - BUSY, accept and not pop -> skid <= in_data, FULL.
  - BUSY, accept and pop -> main <= in_data, stay BUSY.
  - BUSY, pop and not accept -> EMPTY.
  - BUSY, neither -> hold.
  - FULL: pop -> main <= skid, BUSY. No accept is possible in FULL because in_ready = 0.
- Latency: accept in EMPTY gives out_valid = 1 on the next cycle. Throughput is 1 word/cycle when out_ready is held at 1.
- Flush = 1 (highest priority):
  - Next state = EMPTY. Data registers hold their values.
  - A concurrent accept is discarded.
  - A concurrent pop still counts as a completed transfer downstream, since the word was visible.
- Stall: while out_valid = 1 and out_ready = 0, main and out_data must be stable.
- Upstream must not change in_data while in_valid = 1 and in_ready = 0. The buffer does not check this.
- Reset asserted mid-transfer: all words are lost immediately and outputs take their reset values asynchronously.

Optional Feature:
- Macro: PIPE_STALL_COUNT_EN.
- Defined:
  - stall_count port exists.
  - It increments by 1 on every cycle with out_valid = 1 and out_ready = 0.
  - It saturates at all-ones and does not wrap.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset with reset = 0, in_valid = 1, in_data = 0xDEADBEEF -> in_ready = 1, out_valid = 0, out_data = INIT (0). Nothing is captured while in reset.
- Streaming: out_ready = 1, push 0x1, 0x2, 0x3 on consecutive cycles -> out_data shows 0x1, 0x2, 0x3 one cycle later each. in_ready stays 1 throughout.
- Back-pressure: out_ready = 0, push 0xA then 0xB.
  - Expect FULL, in_ready = 0, out_data = 0xA held stable.
  - 0xC offered while FULL is not accepted.
  - Raise out_ready: expect 0xA, 0xB, 0xC in order with no loss.
- Flush while FULL with in_valid = 1 (in_data = 0x55) -> next cycle out_valid = 0, in_ready = 1. 0x55 never appears at the output.
- Reset asserted asynchronously mid-cycle while BUSY -> out_valid drops to 0 before the next clock edge.
- With PIPE_STALL_COUNT_EN:
  - Hold out_ready = 0 for 5 cycles with out_valid = 1 -> stall_count = 5.
  - With CNT_WIDTH = 2, stall 6 cycles -> stall_count = 3 (saturated).
